// File: rtl/i2c_responder_regfile_if.sv
// I2C bus wires between an external bus master and the responder.
// The master drives scl/sda_out; the responder answers on sda_in (1 = released).
interface i2c_responder_regfile_if;
    logic scl;
    logic sda_out;
    logic sda_in;

    modport master (output scl, output sda_out, input sda_in);
    modport slave  (input scl, input sda_out, output sda_in);
endinterface

// File: rtl/i2c_responder_regfile.sv
// I2C responder with a byte register bank: address + pointer + data bytes, auto-incrementing pointer.
// The bus is oversampled in the clk domain; host side gets a registered read port and a write strobe.
module i2c_responder_regfile #(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int         REG_AW   = 3,
    parameter int         SYNC_STG = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    i2c_responder_regfile_if.slave bus,
    input  logic [REG_AW-1:0]     host_addr,
    output logic [7:0]            host_rd_data,
    output logic                  wr_pulse,
    output logic [REG_AW-1:0]     wr_addr,
    output logic [7:0]            wr_data,
    output logic                  busy
);
    localparam int NUM_REGS = 2 ** REG_AW;

    typedef enum logic [3:0] {
        S_IDLE, S_DEV, S_DEV_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RD_ACKCHK, S_WAIT_STOP
    } state_t;

    // Input synchronisers plus one history flop for edge/condition detection
    logic [SYNC_STG-1:0] r_scl_sync, r_sda_sync;
    logic                r_scl_hist, r_sda_hist;
    logic                w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_hist <= 1'b1;
            r_sda_hist <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STG-2:0], bus.scl};
            r_sda_sync <= {r_sda_sync[SYNC_STG-2:0], bus.sda_out};
            r_scl_hist <= r_scl_sync[SYNC_STG-1];
            r_sda_hist <= r_sda_sync[SYNC_STG-1];
        end
    end

    assign w_scl      = r_scl_sync[SYNC_STG-1];
    assign w_sda      = r_sda_sync[SYNC_STG-1];
    assign w_scl_rise = w_scl & ~r_scl_hist;
    assign w_scl_fall = ~w_scl & r_scl_hist;
    assign w_start    = w_scl & r_scl_hist & r_sda_hist & ~w_sda;
    assign w_stop     = w_scl & r_scl_hist & ~r_sda_hist & w_sda;

    state_t            r_state, w_state_nxt;
    logic [7:0]        r_shift, w_shift_nxt;
    logic [3:0]        r_bit_cnt, w_bit_cnt_nxt;
    logic [REG_AW-1:0] r_ptr, w_ptr_nxt;
    logic              r_rw, w_rw_nxt;
    logic              r_sda, w_sda_nxt;
    logic              r_busy, w_busy_nxt;
    logic              w_we;
    logic [7:0]        w_byte, w_rd_byte;
    logic [7:0]        r_regs [NUM_REGS];

    assign w_byte    = {r_shift[6:0], w_sda};
    assign w_rd_byte = r_regs[r_ptr];

    // NOTE: every always_comb output gets a default first, so no path leaves a latch behind.
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_ptr_nxt     = r_ptr;
        w_rw_nxt      = r_rw;
        w_sda_nxt     = r_sda;
        w_busy_nxt    = r_busy;
        w_we          = 1'b0;

        if (w_stop) begin
            w_state_nxt   = S_IDLE;
            w_sda_nxt     = 1'b1;
            w_busy_nxt    = 1'b0;
            w_bit_cnt_nxt = 4'd0;
        end else if (w_start) begin
            w_state_nxt   = S_DEV;
            w_sda_nxt     = 1'b1;
            w_bit_cnt_nxt = 4'd0;
        end else begin
            unique case (r_state)
                S_IDLE, S_WAIT_STOP: ;
                S_DEV, S_PTR, S_WDATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt   = w_byte;
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd7) begin
                            w_bit_cnt_nxt = 4'd0;
                            if (r_state == S_DEV) begin
                                if (w_byte[7:1] == DEV_ADDR) begin
                                    w_rw_nxt    = w_byte[0];
                                    w_busy_nxt  = 1'b1;
                                    w_state_nxt = S_DEV_ACK;
                                end else begin
                                    w_busy_nxt  = 1'b0;
                                    w_state_nxt = S_WAIT_STOP;
                                end
                            end else if (r_state == S_PTR) begin
                                w_ptr_nxt   = w_byte[REG_AW-1:0];
                                w_state_nxt = S_PTR_ACK;
                            end else begin
                                w_we        = 1'b1;
                                w_ptr_nxt   = r_ptr + 1'b1;
                                w_state_nxt = S_WDATA_ACK;
                            end
                        end
                    end
                end
                // First falling edge pulls SDA low for the ACK; the second one ends the ACK bit
                S_DEV_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                    if (w_scl_fall) begin
                        if (r_bit_cnt == 4'd0) begin
                            w_sda_nxt     = 1'b0;
                            w_bit_cnt_nxt = 4'd1;
                        end else begin
                            w_sda_nxt     = 1'b1;
                            w_bit_cnt_nxt = 4'd0;
                            if (r_state == S_DEV_ACK && r_rw) begin
                                w_state_nxt = S_RDATA;
                                w_shift_nxt = w_rd_byte;
                                w_sda_nxt   = w_rd_byte[7];
                            end else if (r_state == S_DEV_ACK) begin
                                w_state_nxt = S_PTR;
                            end else begin
                                w_state_nxt = S_WDATA;
                            end
                        end
                    end
                end
                S_RDATA: begin
                    if (w_scl_rise) begin
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_bit_cnt == 4'd8) begin
                            w_sda_nxt     = 1'b1;
                            w_ptr_nxt     = r_ptr + 1'b1;
                            w_bit_cnt_nxt = 4'd0;
                            w_state_nxt   = S_RD_ACKCHK;
                        end else begin
                            w_shift_nxt = {r_shift[6:0], 1'b0};
                            w_sda_nxt   = r_shift[6];
                        end
                    end
                end
                S_RD_ACKCHK: begin
                    if (w_scl_rise) begin
                        if (w_sda) begin
                            w_busy_nxt  = 1'b0;
                            w_state_nxt = S_WAIT_STOP;
                        end else begin
                            w_bit_cnt_nxt = 4'd1;
                        end
                    end else if (w_scl_fall && r_bit_cnt == 4'd1) begin
                        w_bit_cnt_nxt = 4'd0;
                        w_shift_nxt   = w_rd_byte;
                        w_sda_nxt     = w_rd_byte[7];
                        w_state_nxt   = S_RDATA;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_ptr     <= '0;
            r_rw      <= 1'b0;
            r_sda     <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_ptr     <= w_ptr_nxt;
            r_rw      <= w_rw_nxt;
            r_sda     <= w_sda_nxt;
            r_busy    <= w_busy_nxt;
        end
    end

    logic              r_wr_pulse;
    logic [REG_AW-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
    logic [7:0]        r_host_rd;

    // NOTE: the bank is small and must read back as zero after reset, so it is built from resettable flops, not RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
            r_wr_pulse <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_host_rd  <= '0;
        end else begin
            r_wr_pulse <= w_we;
            r_host_rd  <= r_regs[host_addr];
            if (w_we) begin
                r_regs[r_ptr] <= w_byte;
                r_wr_addr     <= r_ptr;
                r_wr_data     <= w_byte;
            end
        end
    end

    assign bus.sda_in   = r_sda;
    assign busy         = r_busy;
    assign wr_pulse     = r_wr_pulse;
    assign wr_addr      = r_wr_addr;
    assign wr_data      = r_wr_data;
    assign host_rd_data = r_host_rd;
endmodule

// File: tb/tb_i2c_responder_regfile.sv
// Directed bench for i2c_responder_regfile: bit-banged I2C master, write-strobe log and SDA protocol monitor.
module tb_i2c_responder_regfile;
    localparam int Q = 5;  // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] host_addr;
    logic [7:0] host_rd_data;
    logic       wr_pulse;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    i2c_responder_regfile_if bus ();

    i2c_responder_regfile #(.DEV_ADDR(7'h50), .REG_AW(3), .SYNC_STG(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus.slave),
        .host_addr    (host_addr),
        .host_rd_data (host_rd_data),
        .wr_pulse     (wr_pulse),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    // Write-strobe log, busy activity and SDA-change-while-SCL-high monitor
    logic [2:0] wq_addr [$];
    logic [7:0] wq_data [$];
    int         busy_cycles = 0;
    int         proto_viol  = 0;
    logic       sda_prev    = 1'b1;
    logic       rst_prev    = 1'b1;

    always @(negedge clk) begin
        if (wr_pulse === 1'b1) begin
            wq_addr.push_back(wr_addr);
            wq_data.push_back(wr_data);
        end
        if (busy === 1'b1) busy_cycles++;
        if (!rst && !rst_prev && bus.sda_in !== sda_prev && bus.scl === 1'b1) proto_viol++;
        sda_prev = bus.sda_in;
        rst_prev = rst;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bit_clk(input logic b, output logic s);
        bus.sda_out = b;
        wait_q();
        bus.scl = 1'b1;
        wait_q();
        s = bus.sda_in;
        wait_q();
        bus.scl = 1'b0;
        wait_q();
    endtask

    task automatic i2c_start();
        bus.sda_out = 1'b1;
        wait_q();
        bus.scl = 1'b1;
        wait_q();
        bus.sda_out = 1'b0;
        wait_q();
        bus.scl = 1'b0;
        wait_q();
    endtask

    task automatic i2c_stop();
        bus.sda_out = 1'b0;
        wait_q();
        bus.scl = 1'b1;
        wait_q();
        bus.sda_out = 1'b1;
        wait_q();
        wait_q();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_clk(b[i], s);
        bit_clk(1'b1, ack);
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] b);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_clk(1'b1, s);
            b[i] = s;
        end
        bit_clk(mack, s);
    endtask

    task automatic host_read(input logic [2:0] a, output logic [7:0] d);
        host_addr = a;
        @(negedge clk);
        d = host_rd_data;
    endtask

    logic       ack, s;
    logic [7:0] d;
    int         wr_base, busy_base;

    initial begin
        rst         = 1'b1;
        bus.scl     = 1'b1;
        bus.sda_out = 1'b1;
        host_addr   = 3'd0;
        repeat (3) @(negedge clk);
        check("rst_sda_in", 8'(bus.sda_in), 8'h01);
        check("rst_busy", 8'(busy), 8'h00);
        check("rst_wr_pulse", 8'(wr_pulse), 8'h00);
        check("rst_host_rd", host_rd_data, 8'h00);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 1: write 0x11, 0x22 from pointer 2, then 0x55 at 5
        i2c_start();
        send_byte(8'hA0, ack); check("t1_ack_dev", 8'(ack), 8'h00);
        check("t1_busy", 8'(busy), 8'h01);
        send_byte(8'h02, ack); check("t1_ack_ptr", 8'(ack), 8'h00);
        send_byte(8'h11, ack); check("t1_ack_d0", 8'(ack), 8'h00);
        send_byte(8'h22, ack); check("t1_ack_d1", 8'(ack), 8'h00);
        i2c_stop();
        check("t1_busy_stop", 8'(busy), 8'h00);
        check("t1_wr_count", 8'(wq_addr.size()), 8'd2);
        if (wq_addr.size() >= 2) begin
            check("t1_wr0_addr", 8'(wq_addr[0]), 8'h02);
            check("t1_wr0_data", wq_data[0], 8'h11);
            check("t1_wr1_addr", 8'(wq_addr[1]), 8'h03);
            check("t1_wr1_data", wq_data[1], 8'h22);
        end
        host_read(3'd2, d); check("t1_host2", d, 8'h11);
        host_read(3'd3, d); check("t1_host3", d, 8'h22);
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h05, ack);
        send_byte(8'h55, ack); check("t1_ack_r5", 8'(ack), 8'h00);
        i2c_stop();
        host_read(3'd5, d); check("t1_host5", d, 8'h55);

        // 2: pointer write, repeated START, two-byte read, then a pointer-less read at 5
        wr_base = wq_addr.size();
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h03, ack);
        i2c_start();
        send_byte(8'hA1, ack); check("t2_ack_rd", 8'(ack), 8'h00);
        recv_byte(1'b0, d); check("t2_rd0", d, 8'h22);
        recv_byte(1'b1, d); check("t2_rd1", d, 8'h00);
        check("t2_busy_nack", 8'(busy), 8'h00);
        i2c_stop();
        i2c_start();
        send_byte(8'hA1, ack);
        recv_byte(1'b1, d); check("t2_rd_ptr5", d, 8'h55);
        i2c_stop();
        check("t2_no_write", 8'(wq_addr.size() - wr_base), 8'd0);

        // 3: wrong device address is NACKed and everything after it ignored
        wr_base   = wq_addr.size();
        busy_base = busy_cycles;
        i2c_start();
        send_byte(8'hA2, ack); check("t3_nack_dev", 8'(ack), 8'h01);
        send_byte(8'h01, ack); check("t3_nack_b1", 8'(ack), 8'h01);
        send_byte(8'h99, ack); check("t3_nack_b2", 8'(ack), 8'h01);
        i2c_stop();
        check("t3_no_write", 8'(wq_addr.size() - wr_base), 8'd0);
        check("t3_no_busy", 8'(busy_cycles - busy_base), 8'd0);

        // 4: pointer wrap 7 -> 0, and pointer byte 0xFF selecting index 7
        wr_base = wq_addr.size();
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h07, ack);
        send_byte(8'hAA, ack);
        send_byte(8'hBB, ack);
        i2c_stop();
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'hFF, ack);
        send_byte(8'hCC, ack); check("t4_ack_cc", 8'(ack), 8'h00);
        i2c_stop();
        check("t4_wr_count", 8'(wq_addr.size() - wr_base), 8'd3);
        if (wq_addr.size() >= wr_base + 3) begin
            check("t4_wr0_addr", 8'(wq_addr[wr_base]), 8'h07);
            check("t4_wr1_addr", 8'(wq_addr[wr_base+1]), 8'h00);
            check("t4_wr1_data", wq_data[wr_base+1], 8'hBB);
            check("t4_wrff_addr", 8'(wq_addr[wr_base+2]), 8'h07);
        end
        host_read(3'd0, d); check("t4_host0", d, 8'hBB);
        host_read(3'd7, d); check("t4_host7", d, 8'hCC);

        // 5: STOP after a partial data byte, then reset in the middle of a read byte
        wr_base = wq_addr.size();
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h01, ack);
        bit_clk(1'b1, s);
        bit_clk(1'b0, s);
        bit_clk(1'b1, s);
        bit_clk(1'b0, s);
        i2c_stop();
        check("t5_partial_no_wr", 8'(wq_addr.size() - wr_base), 8'd0);
        host_read(3'd1, d); check("t5_host1", d, 8'h00);
        i2c_start();
        send_byte(8'hA0, ack);
        send_byte(8'h07, ack);
        i2c_start();
        send_byte(8'hA1, ack);
        bit_clk(1'b1, s); check("t5_rd_b7", 8'(s), 8'h01);
        bit_clk(1'b1, s); check("t5_rd_b6", 8'(s), 8'h01);
        bus.sda_out = 1'b1;
        wait_q();
        bus.scl = 1'b1;
        wait_q();
        check("t5_rd_b5_low", 8'(bus.sda_in), 8'h00);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_sda", 8'(bus.sda_in), 8'h01);
        check("t5_rst_busy", 8'(busy), 8'h00);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            host_read(3'(i), d);
            check($sformatf("t5_reg%0d_zero", i), d, 8'h00);
        end
        check("t5_no_write", 8'(wq_addr.size() - wr_base), 8'd0);

        // 6: SDA from the responder never moved while SCL was high
        check("t6_protocol", 8'(proto_viol), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
